spi_pwm_sched: RTL and testbench

Command decoder and update scheduler between the SPI slave receive word and the PWM generator. It decodes 32-bit host commands into shadow duty, period and enable registers. It commits them atomically to the active PWM configuration only at a PWM period boundary, which prevents glitched PWM cycles. It also provides back-pressure while a commit is pending, and a status word for the SPI transmit path.

---
 rtl/spi_pwm_sched_if.sv | 32 +++
 rtl/spi_pwm_sched.sv | 161 ++++++++++++++++
 tb/tb_spi_pwm_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_sched_if.sv
// Purpose : bus bundle between the SPI receive path, the PWM counter and the
//           update scheduler.
// Ports   : rx_word/rx_valid/rx_ready - received command word handshake
//           period_end                - PWM wrap pulse
//           duty_act/period_act/ch_en - active PWM configuration
//           busy/err/status           - scheduler status
// Modports: master (host / PWM side), slave (scheduler)
interface spi_pwm_sched_if #(
    parameter int unsigned NCH    = 3,
    parameter int unsigned DUTY_W = 8
);
    logic [31:0]           rx_word;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  period_end;
    logic [NCH*DUTY_W-1:0] duty_act;
    logic [DUTY_W-1:0]     period_act;
    logic [NCH-1:0]        ch_en;
    logic                  busy;
    logic                  err;
    logic [31:0]           status;

    modport master (
        output rx_word, rx_valid, period_end,
        input  rx_ready, duty_act, period_act, ch_en, busy, err, status
    );

    modport slave (
        input  rx_word, rx_valid, period_end,
        output rx_ready, duty_act, period_act, ch_en, busy, err, status
    );
endinterface

// File: rtl/spi_pwm_sched.sv
// Purpose : decodes 32-bit SPI commands into shadow duty/period/enable
//           registers and commits them atomically to the active PWM
//           configuration at a PWM period boundary.
// Ports   : clk - system clock (same as the PWM clock)
//           rst - asynchronous active-high reset
//           bus - spi_pwm_sched_if.slave (rx handshake, period_end,
//                 active configuration, busy/err/status)
// Options : define SPI_PWM_SCHED_WDOG_EN to add a host-silence watchdog that
//           disables all channels and flags err after 2**TO_W-1 idle cycles.
module spi_pwm_sched #(
    parameter int unsigned NCH    = 3,
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned TO_W   = 20
) (
    input  logic            clk,
    input  logic            rst,
    spi_pwm_sched_if.slave  bus
);

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_DUTY   = 4'h1;
    localparam logic [3:0] OP_PERIOD = 4'h2;
    localparam logic [3:0] OP_EN     = 4'h3;
    localparam logic [3:0] OP_COMMIT = 4'h4;
    localparam logic [3:0] OP_CLRERR = 4'h5;
    localparam logic [3:0] NCH_L     = 4'(NCH);

    // Elaboration-time parameter range checks
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("spi_pwm_sched: NCH out of range");
    end
    if (DUTY_W < 4 || DUTY_W > 16) begin : g_bad_duty_w
        $error("spi_pwm_sched: DUTY_W out of range");
    end
    if (TO_W < 2 || TO_W > 32) begin : g_bad_to_w
        $error("spi_pwm_sched: TO_W out of range");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [3:0]        op;
    logic [3:0]        ch;
    logic [DUTY_W-1:0] data;
    logic              accept;

    logic [DUTY_W-1:0] shadow_duty [NCH];
    logic [DUTY_W-1:0] shadow_period;
    logic [NCH-1:0]    shadow_en;
    logic [7:0]        cmd_cnt;
    logic              wdog_fire;

    // Command field decode and next-state logic
    always_comb begin
        op      = bus.rx_word[31:28];
        ch      = bus.rx_word[27:24];
        data    = bus.rx_word[DUTY_W-1:0];
        accept  = bus.rx_valid && bus.rx_ready;
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && op == OP_COMMIT) state_d = PENDING;
            PENDING: if (bus.period_end)            state_d = APPLY;
            APPLY:                                  state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    // Bits of the command word that no opcode uses
    logic unused_rx_bits;
    assign unused_rx_bits = ^bus.rx_word[23:DUTY_W];

`ifdef SPI_PWM_SCHED_WDOG_EN
    // Host-silence counter: cleared by any accepted word, saturates at all ones
    logic [TO_W-1:0] wdog_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (accept) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + TO_W'(1);
        end
    end

    assign wdog_fire = (wdog_cnt == '1);
`else
    assign wdog_fire = 1'b0;
`endif

    // State, shadow, active and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bus.rx_ready   <= 1'b1;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
            cmd_cnt        <= '0;
            shadow_period  <= '1;
            shadow_en      <= '0;
            bus.duty_act   <= '0;
            bus.period_act <= '1;
            bus.ch_en      <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                shadow_duty[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            // Handshake flags follow the state being entered so they stay registered
            bus.rx_ready <= (state_d == IDLE);
            bus.busy     <= (state_d != IDLE);

            if (accept) begin
                cmd_cnt <= cmd_cnt + 8'd1;
                unique case (op)
                    OP_NOP: ;
                    OP_DUTY: begin
                        if (ch < NCH_L) begin
                            for (int unsigned i = 0; i < NCH; i++) begin
                                if (ch == 4'(i)) shadow_duty[i] <= data;
                            end
                        end else begin
                            bus.err <= 1'b1;
                        end
                    end
                    OP_PERIOD: shadow_period <= data;
                    OP_EN:     shadow_en     <= bus.rx_word[NCH-1:0];
                    OP_COMMIT: ;
                    OP_CLRERR: bus.err       <= 1'b0;
                    default:   bus.err       <= 1'b1;
                endcase
            end

            // Atomic commit; duty is clamped so it never exceeds the period
            if (state_q == APPLY) begin
                for (int unsigned i = 0; i < NCH; i++) begin
                    bus.duty_act[i*DUTY_W +: DUTY_W] <=
                        (shadow_duty[i] > shadow_period) ? shadow_period : shadow_duty[i];
                end
                bus.period_act <= shadow_period;
                bus.ch_en      <= shadow_en;
            end

            // Watchdog has the final say over enables and err
            if (wdog_fire) begin
                bus.ch_en <= '0;
                shadow_en <= '0;
                bus.err   <= 1'b1;
            end
        end
    end

    // Status word is pure wiring of registered state
    assign bus.status = {bus.err, bus.busy, 6'b0, cmd_cnt, 8'b0, 8'(bus.ch_en)};

endmodule

// File: tb/tb_spi_pwm_sched.sv
// Purpose : directed self-checking bench for spi_pwm_sched (NCH=3, DUTY_W=8).
//           With SPI_PWM_SCHED_WDOG_EN defined the DUT is built with TO_W=4.
// Ports   : none (top-level bench)
module tb_spi_pwm_sched;

    localparam int unsigned NCH    = 3;
    localparam int unsigned DUTY_W = 8;
`ifdef SPI_PWM_SCHED_WDOG_EN
    localparam int unsigned TO_W   = 4;
`else
    localparam int unsigned TO_W   = 20;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   exp_cnt;

    spi_pwm_sched_if #(.NCH(NCH), .DUTY_W(DUTY_W)) bus ();

    spi_pwm_sched #(.NCH(NCH), .DUTY_W(DUTY_W), .TO_W(TO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle word; caller guarantees rx_ready so the word is counted
    task automatic send(input logic [31:0] w);
        bus.rx_word  = w;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        exp_cnt++;
    endtask

    task automatic pulse();
        bus.period_end = 1'b1;
        @(negedge clk);
        bus.period_end = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_duty"},   32'(bus.duty_act),   32'h0);
        check({tag, "_period"}, 32'(bus.period_act), 32'hFF);
        check({tag, "_chen"},   32'(bus.ch_en),      32'h0);
        check({tag, "_rdy"},    32'(bus.rx_ready),   32'h1);
        check({tag, "_busy"},   32'(bus.busy),       32'h0);
        check({tag, "_status"}, bus.status,          32'h0);
    endtask

    // Absolute time limit so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s;
        n_checks       = 0;
        n_fail         = 0;
        exp_cnt        = 0;
        rst            = 1'b1;
        bus.rx_word    = '0;
        bus.rx_valid   = 1'b0;
        bus.period_end = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // 1. reset state
        check_reset_state("rst");

        // 2. duty ch1, enables, commit; held until period_end
        send(32'h1100_0040);
        send(32'h3000_0007);
        send(32'h4000_0000);
        check("t2_busy",     32'(bus.busy),     32'h1);
        check("t2_rdy",      32'(bus.rx_ready), 32'h0);
        tick(3);
        check("t2_hold",     32'(bus.duty_act), 32'h0);
        // word offered while not ready must be dropped
        bus.rx_word  = 32'h1200_0055;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        pulse();
        check("t2_apply_cyc", 32'(bus.duty_act), 32'h0);
        check("t2_apply_busy", 32'(bus.busy),    32'h1);
        tick(1);
        check("t2_duty",   32'(bus.duty_act), 32'h0000_4000);
        check("t2_chen",   32'(bus.ch_en),    32'h7);
        check("t2_busy0",  32'(bus.busy),     32'h0);
        check("t2_rdy1",   32'(bus.rx_ready), 32'h1);
        check("t2_status", bus.status,        32'h0003_0007);

        // 3. period 0x20, duty ch0 0x80 is clamped; idle period_end ignored
        send(32'h2000_0020);
        send(32'h1000_0080);
        pulse();
        tick(1);
        check("t3_idle_pe", 32'(bus.period_act), 32'hFF);
        send(32'h4000_0000);
        pulse();
        tick(1);
        check("t3_duty",   32'(bus.duty_act),   32'h0000_2020);
        check("t3_period", 32'(bus.period_act), 32'h20);

        // 4. commit accepted together with period_end waits for the next pulse
        send(32'h2000_0030);
        bus.rx_word    = 32'h4000_0000;
        bus.rx_valid   = 1'b1;
        bus.period_end = 1'b1;
        @(negedge clk);
        bus.rx_valid   = 1'b0;
        bus.period_end = 1'b0;
        exp_cnt++;
        tick(2);
        check("t4_busy",   32'(bus.busy),       32'h1);
        check("t4_hold",   32'(bus.period_act), 32'h20);
        pulse();
        tick(1);
        check("t4_period", 32'(bus.period_act), 32'h30);
        check("t4_duty",   32'(bus.duty_act),   32'h0000_3030);
        check("t4_busy0",  32'(bus.busy),       32'h0);

        // 5. errors, clear, count wrap
        send(32'h1500_0011);
        check("t5_err_ch",  bus.status,      32'h8009_0007);
        send(32'h9000_0000);
        check("t5_err_op",  32'(bus.err),    32'h1);
        send(32'h5000_0000);
        check("t5_clr",     32'(bus.err),    32'h0);
        send(32'h4000_0000);
        pulse();
        tick(1);
        check("t5_noshadow", 32'(bus.duty_act), 32'h0000_3030);
        while (exp_cnt < 255) send(32'h0000_0000);
        s = bus.status;
        check("t5_cnt_ff",  32'(s[23:16]),   32'hFF);
        send(32'h0000_0000);
        s = bus.status;
        check("t5_cnt_wrap", 32'(s[23:16]),  32'h00);
        check("t5_status",  bus.status,      32'h0000_0007);

        // host silence: watchdog trip or retention
        tick(20);
`ifdef SPI_PWM_SCHED_WDOG_EN
        check("wdog_chen", 32'(bus.ch_en),    32'h0);
        check("wdog_err",  32'(bus.err),      32'h1);
`else
        check("keep_chen", 32'(bus.ch_en),    32'h7);
        check("keep_err",  32'(bus.err),      32'h0);
        check("keep_duty", 32'(bus.duty_act), 32'h0000_3030);
`endif

        // 6. reset in PENDING clears everything immediately, no partial commit
        send(32'h1200_0011);
        send(32'h4000_0000);
        tick(1);
        check("t6_pending", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        check_reset_state("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        pulse();
        tick(1);
        check("t6_nocommit_duty",   32'(bus.duty_act),   32'h0);
        check("t6_nocommit_period", 32'(bus.period_act), 32'hFF);
        check("t6_idle",            32'(bus.busy),       32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
